// File: rtl/mdbrot_view_ctrl_if.sv
// Command handshake, render handshake and window outputs of the Mandelbrot view controller.
`timescale 1ns/1ps
interface mdbrot_view_ctrl_if;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_ready;
  logic        render_start;
  logic        render_done;
  logic        busy;
  logic [31:0] xmin;
  logic [31:0] xmax;
  logic [31:0] ymin;
  logic [31:0] ymax;
  logic [31:0] Xscale;
  logic [31:0] Yscale;
  logic [12:0] max_iter;

  modport master (
    output cmd_valid, cmd, render_done,
    input  cmd_ready, render_start, busy, xmin, xmax, ymin, ymax, Xscale, Yscale, max_iter
  );

  modport slave (
    input  cmd_valid, cmd, render_done,
    output cmd_ready, render_start, busy, xmin, xmax, ymin, ymax, Xscale, Yscale, max_iter
  );
endinterface

// File: rtl/mdbrot_view_ctrl.sv
// Viewport controller and frame sequencer: holds the Q11.20 complex-plane window
// (20 fractional bits), applies user commands and launches one 160x120 render per command.
`timescale 1ns/1ps
module mdbrot_view_ctrl #(
  parameter logic [31:0] X0        = 32'hFFE00000,
  parameter logic [31:0] Y0        = 32'hFFF00000,
  parameter logic [31:0] SCALE0    = 32'h00004000,
  parameter logic [31:0] MIN_SCALE = 32'h00000001,
  parameter logic [31:0] MAX_SCALE = 32'h00010000,
  parameter logic [31:0] PAN_PX    = 32'd16,
  parameter logic [12:0] ITER      = 13'd64
) (
  input logic               clk,
  input logic               rst,
  mdbrot_view_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, APPLY, BOUNDS, LAUNCH, WAIT} state_t;

  localparam logic [2:0] CMD_REDRAW   = 3'd0;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
  localparam logic [2:0] CMD_ZOOM_OUT = 3'd2;
  localparam logic [2:0] CMD_LEFT     = 3'd3;
  localparam logic [2:0] CMD_RIGHT    = 3'd4;
  localparam logic [2:0] CMD_UP       = 3'd5;
  localparam logic [2:0] CMD_DOWN     = 3'd6;
  localparam logic [2:0] CMD_RESET    = 3'd7;

  localparam logic [31:0] XMAX0 = X0 + 32'd160 * SCALE0;
  localparam logic [31:0] YMAX0 = Y0 + 32'd120 * SCALE0;

  state_t      state;
  logic [31:0] xmin, xmax, ymin, ymax, scale;
  logic        pend_full;
  logic [2:0]  pend_cmd;
  logic        render_start;
  logic        busy;
  logic        accept;

  // Shift-add products of the current scale: zoom re-centring offsets and window spans.
  logic [31:0] s40, s30, s80, s60, span_x, span_y, pan;
  assign s40    = (scale << 5) + (scale << 3);
  assign s30    = (scale << 5) - (scale << 1);
  assign s80    = (scale << 6) + (scale << 4);
  assign s60    = (scale << 6) - (scale << 2);
  assign span_x = (scale << 7) + (scale << 5);
  assign span_y = (scale << 7) - (scale << 3);
  assign pan    = scale * PAN_PX;

  // Ready must drop while reset is asserted even though the state already reads IDLE.
  assign bus.cmd_ready    = rst && ((state == IDLE) || ((state == WAIT) && !pend_full));
  assign accept           = bus.cmd_valid && bus.cmd_ready;
  assign bus.render_start = render_start;
  assign bus.busy         = busy;
  assign bus.xmin         = xmin;
  assign bus.xmax         = xmax;
  assign bus.ymin         = ymin;
  assign bus.ymax         = ymax;
  assign bus.Xscale       = scale;
  assign bus.Yscale       = scale;
  assign bus.max_iter     = ITER;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pend_full    <= 1'b0;
      pend_cmd     <= CMD_REDRAW;
      render_start <= 1'b0;
      busy         <= 1'b0;
      xmin         <= X0;
      ymin         <= Y0;
      scale        <= SCALE0;
      xmax         <= XMAX0;
      ymax         <= YMAX0;
    end else begin
      render_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pend_cmd  <= bus.cmd;
            pend_full <= 1'b1;
            busy      <= 1'b1;
            state     <= APPLY;
          end
        end
        APPLY: begin
          pend_full <= 1'b0;
          state     <= BOUNDS;
          case (pend_cmd)
            CMD_ZOOM_IN: begin
              if (scale > MIN_SCALE) begin
                xmin  <= xmin + s40;
                ymin  <= ymin + s30;
                scale <= scale >> 1;
              end
            end
            CMD_ZOOM_OUT: begin
              if (scale < MAX_SCALE) begin
                xmin  <= xmin - s80;
                ymin  <= ymin - s60;
                scale <= scale << 1;
              end
            end
            CMD_LEFT:  xmin <= xmin - pan;
            CMD_RIGHT: xmin <= xmin + pan;
            CMD_UP:    ymin <= ymin - pan;
            CMD_DOWN:  ymin <= ymin + pan;
            CMD_RESET: begin
              xmin  <= X0;
              ymin  <= Y0;
              scale <= SCALE0;
            end
            default: ;
          endcase
        end
        BOUNDS: begin
          xmax         <= xmin + span_x;
          ymax         <= ymin + span_y;
          render_start <= 1'b1;
          state        <= LAUNCH;
        end
        LAUNCH: state <= WAIT;
        // A command accepted in the same cycle as render_done still counts as queued.
        WAIT: begin
          if (accept) begin
            pend_cmd  <= bus.cmd;
            pend_full <= 1'b1;
          end
          if (bus.render_done) begin
            if (pend_full || accept) begin
              state <= APPLY;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pend_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdbrot_view_ctrl.sv
// Randomised self-checking bench for mdbrot_view_ctrl against a plain-arithmetic window model.
`timescale 1ns/1ps
module tb_mdbrot_view_ctrl;

  localparam logic [31:0]  X0        = 32'hFFE00000;
  localparam logic [31:0]  Y0        = 32'hFFF00000;
  localparam logic [31:0]  SCALE0    = 32'h00004000;
  localparam logic [31:0]  MIN_SCALE = 32'h00000001;
  localparam logic [31:0]  MAX_SCALE = 32'h00010000;
  localparam logic [191:0] RESET_WIN = {32'hFFE00000, 32'h00080000, 32'hFFF00000,
                                        32'h000E0000, 32'h00004000, 32'h00004000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] mx, my, ms;

  mdbrot_view_ctrl_if bus ();

  mdbrot_view_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window model: applies each command's rule directly with ordinary 32-bit arithmetic.
  task automatic model_reset();
    mx = X0;
    my = Y0;
    ms = SCALE0;
  endtask

  task automatic model_apply(input logic [2:0] c);
    case (c)
      3'd1: if (ms > MIN_SCALE) begin
        mx = mx + 32'd40 * ms;
        my = my + 32'd30 * ms;
        ms = ms / 2;
      end
      3'd2: if (ms < MAX_SCALE) begin
        mx = mx - 32'd80 * ms;
        my = my - 32'd60 * ms;
        ms = ms * 2;
      end
      3'd3: mx = mx - 32'd16 * ms;
      3'd4: mx = mx + 32'd16 * ms;
      3'd5: my = my - 32'd16 * ms;
      3'd6: my = my + 32'd16 * ms;
      3'd7: model_reset();
      default: ;
    endcase
  endtask

  function automatic logic [191:0] model_window();
    return {mx, mx + 32'd160 * ms, my, my + 32'd120 * ms, ms, ms};
  endfunction

  function automatic logic [191:0] dut_window();
    return {bus.xmin, bus.xmax, bus.ymin, bus.ymax, bus.Xscale, bus.Yscale};
  endfunction

  task automatic do_reset();
    bus.cmd_valid   = 1'b0;
    bus.cmd         = 3'd0;
    bus.render_done = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  // Called in the APPLY cycle; returns cycles since the accept cycle and the window at render_start.
  task automatic launch_capture(output int lat, output logic [191:0] win);
    lat = 1;
    while (bus.render_start !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    win = dut_window();
    tick();
  endtask

  task automatic accept_idle(input logic [2:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic finish_frame();
    bus.render_done = 1'b1;
    tick();
    bus.render_done = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] c, output int lat, output logic [191:0] win);
    accept_idle(c);
    launch_capture(lat, win);
    finish_frame();
  endtask

  task automatic test_reset();
    int starts;
    bus.cmd_valid   = 1'b0;
    bus.cmd         = 3'd0;
    bus.render_done = 1'b0;
    rst = 1'b0;
    tick();
    tests_run++;
    if ({bus.cmd_ready, bus.busy, bus.render_start} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_held_ctrl: ready/busy/start=%b required 000",
               {bus.cmd_ready, bus.busy, bus.render_start});
    end
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    tests_run++;
    if (dut_window() !== RESET_WIN) begin
      tests_failed++;
      $display("[TB] FAIL reset_window: got %h required %h", dut_window(), RESET_WIN);
    end
    tests_run++;
    if (bus.max_iter !== 13'd64) begin
      tests_failed++;
      $display("[TB] FAIL max_iter: got %0d required 64", bus.max_iter);
    end
    tests_run++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: ready/busy=%b required 10", {bus.cmd_ready, bus.busy});
    end
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.render_start !== 1'b0) starts++;
    end
    tests_run++;
    if (starts != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_start: saw %0d render_start cycles, required 0", starts);
    end
  endtask

  task automatic test_zoom_in();
    logic rdy_seen;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd1;
    tick();
    bus.cmd_valid = 1'b0;
    model_apply(3'd1);
    rdy_seen = bus.cmd_ready;
    tick();
    rdy_seen = rdy_seen | bus.cmd_ready;
    tick();
    rdy_seen = rdy_seen | bus.cmd_ready;
    tests_run++;
    if (rdy_seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_ready_busy: cmd_ready seen=%b required 0", rdy_seen);
    end
    tests_run++;
    if (bus.render_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_latency: render_start at t+3=%b required 1", bus.render_start);
    end
    tests_run++;
    if (dut_window() !== model_window()) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_window: got %h required %h", dut_window(), model_window());
    end
    tick();
    tests_run++;
    if ({bus.render_start, bus.cmd_ready, bus.busy} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_wait: start/ready/busy=%b required 011",
               {bus.render_start, bus.cmd_ready, bus.busy});
    end
    finish_frame();
    tests_run++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_idle: ready/busy=%b required 10", {bus.cmd_ready, bus.busy});
    end
  endtask

  task automatic test_queue();
    int lat;
    int bad;
    logic [191:0] win;
    do_reset();
    accept_idle(3'd4);
    model_apply(3'd4);
    launch_capture(lat, win);
    tests_run++;
    if (lat !== 3 || win[191:160] !== 32'hFFE40000 || win !== model_window()) begin
      tests_failed++;
      $display("[TB] FAIL queue_right: lat=%0d win=%h required lat=3 win=%h", lat, win, model_window());
    end
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL queue_wait_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd2;
    tick();
    bus.cmd = 3'd3;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || dut_window() !== model_window()) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL queue_full_hold: %0d bad cycles, required 0", bad);
    end
    bus.render_done = 1'b1;
    tick();
    bus.render_done = 1'b0;
    model_apply(3'd2);
    tests_run++;
    if ({bus.busy, bus.cmd_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL queue_apply: busy/ready=%b required 10", {bus.busy, bus.cmd_ready});
    end
    launch_capture(lat, win);
    tests_run++;
    if (lat !== 3 || win[31:0] !== 32'h00008000 || win !== model_window()) begin
      tests_failed++;
      $display("[TB] FAIL queue_zoom_out: lat=%0d win=%h required lat=3 win=%h", lat, win, model_window());
    end
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL queue_third_ready: cmd_ready=%b required 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    model_apply(3'd3);
    finish_frame();
    launch_capture(lat, win);
    tests_run++;
    if (lat !== 3 || win !== model_window()) begin
      tests_failed++;
      $display("[TB] FAIL queue_third: lat=%0d win=%h required lat=3 win=%h", lat, win, model_window());
    end
    finish_frame();
  endtask

  task automatic test_limits();
    int lat;
    int bad;
    logic [191:0] win;
    logic [191:0] prev;
    do_reset();
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      model_apply(3'd1);
      do_cmd(3'd1, lat, win);
      if (lat !== 3 || win !== model_window()) bad++;
    end
    tests_run++;
    if (bad != 0 || bus.Xscale !== 32'h00000001) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_floor: %0d bad frames, scale=%h required 0 bad, scale 00000001",
               bad, bus.Xscale);
    end
    prev = dut_window();
    do_cmd(3'd1, lat, win);
    tests_run++;
    if (lat !== 3 || win !== prev) begin
      tests_failed++;
      $display("[TB] FAIL zoom_in_at_min: lat=%0d win=%h required lat=3 win=%h", lat, win, prev);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      model_apply(3'd2);
      do_cmd(3'd2, lat, win);
    end
    tests_run++;
    if (bus.Xscale !== 32'h00010000 || dut_window() !== model_window()) begin
      tests_failed++;
      $display("[TB] FAIL zoom_out_ceiling: win=%h required %h", dut_window(), model_window());
    end
    prev = dut_window();
    do_cmd(3'd2, lat, win);
    tests_run++;
    if (lat !== 3 || win !== prev) begin
      tests_failed++;
      $display("[TB] FAIL zoom_out_at_max: lat=%0d win=%h required lat=3 win=%h", lat, win, prev);
    end
  endtask

  task automatic test_reset_midframe();
    int lat;
    int bad;
    logic [191:0] win;
    do_reset();
    accept_idle(3'd5);
    launch_capture(lat, win);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (dut_window() !== RESET_WIN || {bus.cmd_ready, bus.busy, bus.render_start} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: win=%h ctrl=%b required win=%h ctrl=000",
               dut_window(), {bus.cmd_ready, bus.busy, bus.render_start}, RESET_WIN);
    end
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    finish_frame();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.render_start !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
          dut_window() !== model_window()) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL stray_done: %0d bad idle cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat_bad;
    int win_bad;
    int b2b_bad;
    int n_b2b;
    logic [191:0] win;
    logic [2:0] c;
    logic [2:0] nxt;
    do_reset();
    lat_bad = 0;
    win_bad = 0;
    b2b_bad = 0;
    n_b2b   = 0;
    c = 3'($urandom_range(0, 6));
    accept_idle(c);
    for (int i = 0; i < 40; i++) begin
      model_apply(c);
      launch_capture(lat, win);
      if (lat !== 3) lat_bad++;
      if (win !== model_window()) begin
        win_bad++;
        $display("[TB] FAIL random_window %0d cmd %0d: got %h required %h", i, c, win, model_window());
      end
      repeat ($urandom_range(0, 2)) tick();
      nxt = 3'($urandom_range(0, 7));
      if (i == 39) begin
        finish_frame();
      end else if ($urandom_range(0, 1) == 1) begin
        n_b2b++;
        if (bus.cmd_ready !== 1'b1) b2b_bad++;
        bus.render_done = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd         = nxt;
        tick();
        bus.render_done = 1'b0;
        bus.cmd_valid   = 1'b0;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) b2b_bad++;
      end else begin
        finish_frame();
        if (bus.busy !== 1'b0) b2b_bad++;
        accept_idle(nxt);
      end
      c = nxt;
    end
    tests_run++;
    if (lat_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL random_latency: %0d frames off, required 0", lat_bad);
    end
    tests_run++;
    if (win_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL random_windows: %0d frames wrong, required 0", win_bad);
    end
    tests_run++;
    if (b2b_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: %0d bad handoffs of %0d, required 0", b2b_bad, n_b2b);
    end
    model_apply(3'd7);
    do_cmd(3'd7, lat, win);
    tests_run++;
    if (lat !== 3 || win !== RESET_WIN) begin
      tests_failed++;
      $display("[TB] FAIL reset_view: lat=%0d win=%h required lat=3 win=%h", lat, win, RESET_WIN);
    end
  endtask

  initial begin
    test_reset();
    test_zoom_in();
    test_queue();
    test_limits();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
